color_key_sequencer: RTL and testbench

Sequencing controller between the PS/2 scan-code receiver and the VGA color path. It parses the raw PS/2 set-2 byte stream, including make, break, E0-extended and typematic-repeat bytes, and maps color-key presses to a 3-bit RGB selection. Each selection is held as pending and committed to the pixel path only on a frame-start strobe, so color never changes mid-frame. It also flags prefix sequences that stall.

---
 rtl/color_key_sequencer.sv | 152 +++++++++++++++
 tb/tb_color_key_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/color_key_sequencer.sv
// PS/2 set-2 scan-code parser that maps color keys to a pending RGB selection
// and commits it to the pixel path only on frame start; flags stalled prefixes.
module color_key_sequencer #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  RESET_COLOR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  input  logic       frameStart,
  output logic [2:0] outColor,
  output logic       colorUpdate,
  output logic       pending,
  output logic       keyHeld,
  output logic       seqError,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    held_code_q, held_code_d;
  logic          key_held_q, key_held_d;
  logic          pending_q, pending_d;
  logic [2:0]    pend_color_q, pend_color_d;
  logic [2:0]    out_color_q, out_color_d;
  logic          color_update_q, color_update_d;
  logic          seq_error_q, seq_error_d;

  logic          is_mapped;
  logic [2:0]    map_color;

  always_comb begin
    is_mapped = 1'b1;
    map_color = 3'b000;
    case (scanCode)
      8'h2D:   map_color = 3'b100;
      8'h34:   map_color = 3'b010;
      8'h32:   map_color = 3'b001;
      8'h1D:   map_color = 3'b111;
      8'h29:   map_color = 3'b000;
      default: is_mapped = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    held_code_d    = held_code_q;
    key_held_d     = key_held_q;
    pending_d      = pending_q;
    pend_color_d   = pend_color_q;
    out_color_d    = out_color_q;
    color_update_d = 1'b0;
    seq_error_d    = 1'b0;

    // Commit first so a make on the same edge re-arms pending with its own color.
    if (frameStart && pending_q) begin
      out_color_d    = pend_color_q;
      pending_d      = 1'b0;
      color_update_d = 1'b1;
    end

    if (scanValid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (scanCode == PFX_EXT) begin
            state_d = ST_EXT;
          end else if (scanCode == PFX_BRK) begin
            state_d = ST_BRK;
          end else if (is_mapped && (scanCode != held_code_q)) begin
            pend_color_d = map_color;
            pending_d    = 1'b1;
            held_code_d  = scanCode;
            key_held_d   = 1'b1;
          end
        end
        ST_EXT: begin
          if (scanCode == PFX_BRK)      state_d = ST_EXT_BRK;
          else if (scanCode != PFX_EXT) state_d = ST_IDLE;
        end
        ST_BRK: begin
          if (scanCode == PFX_EXT) begin
            state_d = ST_EXT_BRK;
          end else if (scanCode != PFX_BRK) begin
            state_d = ST_IDLE;
            if (scanCode == held_code_q) begin
              held_code_d = 8'h00;
              key_held_d  = 1'b0;
            end
          end
        end
        default: begin
          if ((scanCode != PFX_EXT) && (scanCode != PFX_BRK)) state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      state_d     = ST_IDLE;
      seq_error_d = 1'b1;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      held_code_q    <= 8'h00;
      key_held_q     <= 1'b0;
      pending_q      <= 1'b0;
      pend_color_q   <= RESET_COLOR;
      out_color_q    <= RESET_COLOR;
      color_update_q <= 1'b0;
      seq_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      held_code_q    <= held_code_d;
      key_held_q     <= key_held_d;
      pending_q      <= pending_d;
      pend_color_q   <= pend_color_d;
      out_color_q    <= out_color_d;
      color_update_q <= color_update_d;
      seq_error_q    <= seq_error_d;
    end
  end

  assign outColor    = out_color_q;
  assign colorUpdate = color_update_q;
  assign pending     = pending_q;
  assign keyHeld     = key_held_q;
  assign seqError    = seq_error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_color_key_sequencer.sv
// Directed bench for color_key_sequencer: commits are scoreboarded through an
// expected-color queue popped on each colorUpdate pulse; other outputs checked inline.
module tb_color_key_sequencer;

  localparam int T = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BRK  = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       scanValid = 1'b0;
  logic       frameStart = 1'b0;
  logic [2:0] outColor;
  logic       colorUpdate;
  logic       pending;
  logic       keyHeld;
  logic       seqError;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int updates_seen = 0;
  int err_pulses = 0;
  logic [2:0] exp_q[$];

  color_key_sequencer #(.TIMEOUT_CYCLES(T), .RESET_COLOR(3'b000)) dut (
    .clk(clk), .reset(reset), .scanCode(scanCode), .scanValid(scanValid),
    .frameStart(frameStart), .outColor(outColor), .colorUpdate(colorUpdate),
    .pending(pending), .keyHeld(keyHeld), .seqError(seqError), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (colorUpdate) begin
      updates_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected act=%b exp=no_update", outColor);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (outColor !== e) begin
          errors++;
          $display("FAIL commit_color act=%b exp=%b", outColor, e);
        end
      end
    end
    if (seqError) err_pulses++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scanCode = b;
    scanValid = 1'b1;
    @(negedge clk);
    scanValid = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_out", {5'd0, outColor}, 8'h00);
    check("rst_pending", {7'd0, pending}, 8'h00);
    check("rst_keyheld", {7'd0, keyHeld}, 8'h00);
    check("rst_update", {7'd0, colorUpdate}, 8'h00);
    check("rst_seqerr", {7'd0, seqError}, 8'h00);
    check("rst_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
    reset = 1'b1;

    // red make then commit
    send_byte(8'h2D);
    check("r_pending", {7'd0, pending}, 8'h01);
    check("r_keyheld", {7'd0, keyHeld}, 8'h01);
    exp_q.push_back(3'b100);
    frame();
    check("r_out", {5'd0, outColor}, 8'h04);
    check("r_pending_clr", {7'd0, pending}, 8'h00);
    check("r_keyheld_stay", {7'd0, keyHeld}, 8'h01);
    @(negedge clk);
    check("r_update_once", {7'd0, colorUpdate}, 8'h00);
    send_byte(8'h2D);
    check("r_repeat_ignored", {7'd0, pending}, 8'h00);

    // typematic green then break
    send_byte(8'h34);
    send_byte(8'h34);
    send_byte(8'h34);
    check("g_pending", {7'd0, pending}, 8'h01);
    send_byte(8'hF0);
    send_byte(8'h34);
    check("g_keyheld_clr", {7'd0, keyHeld}, 8'h00);
    check("g_pending_kept", {7'd0, pending}, 8'h01);
    exp_q.push_back(3'b010);
    frame();
    check("g_out", {5'd0, outColor}, 8'h02);

    // extended make and extended break are swallowed
    send_byte(8'hE0);
    send_byte(8'h2D);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h2D);
    check("ext_pending", {7'd0, pending}, 8'h00);
    check("ext_keyheld", {7'd0, keyHeld}, 8'h00);
    check("ext_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
    frame();
    check("ext_out", {5'd0, outColor}, 8'h02);

    // prefix timeout: error pulse 8 cycles after F0 is sampled
    send_byte(8'hF0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("to_seqerr_c%0d", i), {7'd0, seqError}, (i == 8) ? 8'h01 : 8'h00);
      if (i == 7) check("to_state_brk", {6'd0, dbg_state}, {6'd0, S_BRK});
      if (i == 8) check("to_state_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
    end
    send_byte(8'h32);
    check("b_pending", {7'd0, pending}, 8'h01);
    check("b_keyheld", {7'd0, keyHeld}, 8'h01);

    // commit and new make on the same edge
    @(negedge clk);
    frameStart = 1'b1;
    scanCode = 8'h1D;
    scanValid = 1'b1;
    exp_q.push_back(3'b001);
    @(negedge clk);
    frameStart = 1'b0;
    scanValid = 1'b0;
    check("sim_out", {5'd0, outColor}, 8'h01);
    check("sim_pending", {7'd0, pending}, 8'h01);
    exp_q.push_back(3'b111);
    frame();
    check("w_out", {5'd0, outColor}, 8'h07);

    // byte on the terminal-count cycle wins over the timeout
    send_byte(8'hF0);
    repeat (6) @(negedge clk);
    send_byte(8'h1D);
    check("tc_keyheld_clr", {7'd0, keyHeld}, 8'h00);
    check("tc_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
    repeat (12) @(negedge clk);
    check("tc_err_pulses", err_pulses[7:0], 8'h01);

    // asynchronous reset mid-sequence
    send_byte(8'h2D);
    check("mr_pending", {7'd0, pending}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("mr_out", {5'd0, outColor}, 8'h00);
    check("mr_pending_clr", {7'd0, pending}, 8'h00);
    check("mr_keyheld_clr", {7'd0, keyHeld}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    frame();
    repeat (2) @(negedge clk);
    check("mr_out_after_frame", {5'd0, outColor}, 8'h00);

    // final report
    check("sb_updates", updates_seen[7:0], 8'h04);
    check("sb_queue_empty", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
